i2c_master_byte_engine: RTL and testbench

Bit-level I2C master that generates SCL/SDA waveforms. It sits directly downstream of the AXI4-Lite I2C register block, which issues one byte-level command at a time through a valid/ready handshake. Each command can combine an optional START (or repeated START), an optional byte write or byte read with ACK handling, and an optional STOP. Pins are open-drain: the engine only pulls SCL/SDA low or releases them, and pad buffers sit outside the block.

---
 rtl/i2c_master_byte_engine.sv | 171 +++++++++++++++++
 tb/tb_i2c_master_byte_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte_engine.sv
// Byte-level I2C master: turns one START/WRITE/READ/STOP command into
// open-drain SCL/SDA activity. Each bit is four quarter phases of DIV clocks.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for a command, lines held
// START   | (repeated) START condition
// WBIT    | shifting tx byte out, MSB first
// WACK    | releasing SDA and sampling slave ACK
// RBIT    | sampling slave data, MSB first
// RACK    | driving ACK/NACK back to the slave
// STOP    | STOP condition
// DONE    | one-cycle completion pulse, ready for the next command
module i2c_master_byte_engine #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic       cmd_nack,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_nack,
    output logic       done,
    output logic       bus_owned,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP, S_DONE
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [1:0]  q;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        wr_r, rd_r, stop_r, nack_r;
    logic        scl_hold, sda_hold;
    logic        accept, active, stall, q_end, ph_end;
    state_t      first_ph, after_start, after_byte;

    assign accept = cmd_valid && cmd_ready;
    assign active = (state != S_IDLE) && (state != S_DONE);
    // A slave holding SCL low in Q1 freezes the quarter until SCL is seen high.
    assign stall  = active && (q == 2'd1) && !scl_i;
    assign q_end  = active && !stall && (cnt == 16'd0);
    assign ph_end = q_end && (q == 2'd3);

    // Phase ordering: START, then byte (write wins over read), then STOP.
    always_comb begin
        first_ph    = cmd_start ? S_START :
                      cmd_write ? S_WBIT  :
                      cmd_read  ? S_RBIT  :
                      cmd_stop  ? S_STOP  : S_DONE;
        after_byte  = stop_r ? S_STOP : S_DONE;
        after_start = wr_r ? S_WBIT : (rd_r ? S_RBIT : after_byte);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = first_ph;
            S_DONE:  state_nxt = accept ? first_ph : S_IDLE;
            S_START: if (ph_end) state_nxt = after_start;
            S_WBIT:  if (ph_end && bit_idx == 3'd7) state_nxt = S_WACK;
            S_RBIT:  if (ph_end && bit_idx == 3'd7) state_nxt = S_RACK;
            S_WACK,
            S_RACK:  if (ph_end) state_nxt = after_byte;
            S_STOP:  if (ph_end) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pin and handshake outputs; lines keep their last level outside active phases.
    always_comb begin
        scl_oe    = scl_hold;
        sda_oe    = sda_hold;
        done      = (state == S_DONE);
        cmd_ready = (state == S_IDLE) || (state == S_DONE);
        unique case (state)
            S_START: begin
                sda_oe = (q >= 2'd2);
                if (q != 2'd0) scl_oe = (q == 2'd3);
            end
            S_WBIT: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = !shreg[7];
            end
            S_WACK, S_RBIT: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = 1'b0;
            end
            S_RACK: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = !nack_r;
            end
            S_STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = (q != 2'd3);
            end
            default: ;
        endcase
    end

    // Quarter divider, bit counter, shift register and status flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            q         <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wr_r      <= 1'b0;
            rd_r      <= 1'b0;
            stop_r    <= 1'b0;
            nack_r    <= 1'b0;
            rx_byte   <= '0;
            rx_nack   <= 1'b0;
            bus_owned <= 1'b0;
            scl_hold  <= 1'b0;
            sda_hold  <= 1'b0;
        end else begin
            scl_hold <= scl_oe;
            sda_hold <= sda_oe;
            if (accept) begin
                cnt     <= DIV_M1;
                q       <= 2'd0;
                bit_idx <= 3'd0;
                shreg   <= tx_byte;
                wr_r    <= cmd_write;
                rd_r    <= cmd_read;
                stop_r  <= cmd_stop;
                nack_r  <= cmd_nack;
            end else if (q_end) begin
                cnt <= DIV_M1;
                q   <= q + 2'd1;
                if (q == 2'd2) begin
                    if (state == S_RBIT) shreg   <= {shreg[6:0], sda_i};
                    if (state == S_WACK) rx_nack <= sda_i;
                end
                if (q == 2'd3) begin
                    if (state == S_WBIT) shreg <= {shreg[6:0], 1'b0};
                    if (state == S_WBIT || state == S_RBIT) bit_idx <= bit_idx + 3'd1;
                    if (state == S_RBIT && bit_idx == 3'd7) rx_byte <= shreg;
                    if (state == S_START) bus_owned <= 1'b1;
                    if (state == S_STOP)  bus_owned <= 1'b0;
                end
            end else if (active && !stall) begin
                cnt <= cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// Directed bench for the I2C byte engine. Stimulus pushes expected results
// into a scoreboard; a negedge monitor watches the bus and pops on done.
module tb_i2c_master_byte_engine;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0, cmd_write = 1'b0, cmd_read = 1'b0;
    logic       cmd_stop = 1'b0, cmd_nack = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       cmd_ready, rx_nack, done, bus_owned, scl_oe, sda_oe;
    logic [7:0] rx_byte;
    logic       scl_i, sda_i;

    logic       stretch = 1'b0;
    logic       slave_sda = 1'b1;
    logic       slave_en = 1'b0;
    int         slave_q0 = 0;
    logic [8:0] slave_data = 9'h1FF;
    logic       stretch_en = 1'b0;

    assign scl_i = !scl_oe && !stretch;
    assign sda_i = !sda_oe && slave_sda;

    i2c_master_byte_engine #(.DIV(DIV)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_stop(cmd_stop), .cmd_nack(cmd_nack), .tx_byte(tx_byte),
        .rx_byte(rx_byte), .rx_nack(rx_nack), .done(done),
        .bus_owned(bus_owned), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         lat;
        logic [7:0] rx;
        logic       nack;
        logic       bo;
        logic       bo_seen;
        int         nbits;
        logic [31:0] log_bits;
        int         nstart;
        int         nstop;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;

    int          rel;
    logic        scl_prev = 1'b1, sda_prev = 1'b1;
    int          nbits = 0, nstart = 0, nstop = 0;
    logic [31:0] log_bits = '0;
    logic        bo_seen = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(input string n, input int lat, input logic [7:0] rx,
                                input logic nack, input logic bo, input logic bos,
                                input int nb, input logic [31:0] lg, input int ns, input int np);
        exp_t e;
        e.name = n; e.lat = lat; e.rx = rx; e.nack = nack; e.bo = bo;
        e.bo_seen = bos; e.nbits = nb; e.log_bits = lg; e.nstart = ns; e.nstop = np;
        return e;
    endfunction

    // cycle counter and accept timestamp
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cyc <= cyc;
        cyc <= cyc + 1;
    end

    // slave model, bus event recorder and scoreboard checker
    always @(negedge clk) begin
        int   qq;
        logic scl_ln, sda_ln;
        exp_t e;
        rel = cyc - acc_cyc;
        qq  = (rel - 1) / DIV - slave_q0;
        slave_sda = (slave_en && rel >= 1 && qq >= 0 && qq < 36) ? slave_data[8 - qq / 4] : 1'b1;
        stretch   = stretch_en && rel >= 5 && rel <= 24;
        scl_ln = !scl_oe && !stretch;
        sda_ln = !sda_oe && slave_sda;
        if (rel == 1) begin
            nbits = 0; nstart = 0; nstop = 0; log_bits = '0; bo_seen = 1'b0;
        end
        if (resetn) begin
            if (scl_prev && scl_ln && sda_prev && !sda_ln) nstart++;
            if (scl_prev && scl_ln && !sda_prev && sda_ln) nstop++;
            if (!scl_prev && scl_ln) begin
                log_bits = {log_bits[30:0], sda_ln};
                nbits++;
            end
            if (bus_owned) bo_seen = 1'b1;
        end
        scl_prev = scl_ln;
        sda_prev = sda_ln;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".latency"}, rel, e.lat);
                chk({e.name, ".rx_byte"}, int'(rx_byte), int'(e.rx));
                chk({e.name, ".rx_nack"}, int'(rx_nack), int'(e.nack));
                chk({e.name, ".bus_owned"}, int'(bus_owned), int'(e.bo));
                chk({e.name, ".bus_owned_seen"}, int'(bo_seen), int'(e.bo_seen));
                chk({e.name, ".cmd_ready"}, int'(cmd_ready), 1);
                chk({e.name, ".scl_rises"}, nbits, e.nbits);
                chk({e.name, ".sda_bits"}, int'(log_bits), int'(e.log_bits));
                chk({e.name, ".starts"}, nstart, e.nstart);
                chk({e.name, ".stops"}, nstop, e.nstop);
            end
        end
    end

    task automatic issue(input logic s, input logic w, input logic r, input logic p,
                         input logic n, input logic [7:0] b, input logic sl_en,
                         input int sl_q0, input logic [8:0] sl_data, input logic st_en);
        slave_en   = 1'b0;
        stretch_en = 1'b0;
        @(negedge clk);
        cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p; cmd_nack = n;
        tx_byte = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_start = 1'b0; cmd_write = 1'b0; cmd_read = 1'b0; cmd_stop = 1'b0;
        cmd_nack = 1'b0; tx_byte = 8'h00;
        slave_en = sl_en; slave_q0 = sl_q0; slave_data = sl_data; stretch_en = st_en;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        bit seen;
        start_cnt = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk);
            if (done_cnt != start_cnt) seen = 1'b1;
        end
        if (!seen) chk("wait_done_timeout", 0, 1);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.cmd_ready", int'(cmd_ready), 1);
        chk("rst.done", int'(done), 0);
        chk("rst.rx_byte", int'(rx_byte), 0);
        chk("rst.rx_nack", int'(rx_nack), 0);
        chk("rst.bus_owned", int'(bus_owned), 0);
        chk("rst.scl_oe", int'(scl_oe), 0);
        chk("rst.sda_oe", int'(sda_oe), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // START + WRITE A5 + STOP, slave ACKs
        sb.push_back(mk("start_wr_a5_stop", 177, 8'h00, 1'b0, 1'b0, 1'b1, 10, 32'b1010010100, 1, 1));
        issue(1, 1, 0, 1, 0, 8'hA5, 1'b1, 4, 9'h1FE, 1'b0);
        wait_done(400);
        chk("a5.scl_released", int'(scl_oe), 0);
        chk("a5.sda_released", int'(sda_oe), 0);

        // WRITE 3C with nobody answering
        sb.push_back(mk("wr_3c_noack", 145, 8'h00, 1'b1, 1'b0, 1'b0, 9, 32'b001111001, 0, 0));
        issue(0, 1, 0, 0, 0, 8'h3C, 1'b0, 0, 9'h1FF, 1'b0);
        wait_done(400);

        // START + READ 96 with NACK + STOP
        sb.push_back(mk("start_rd_96_stop", 177, 8'h96, 1'b1, 1'b0, 1'b1, 11, 32'b11001011010, 1, 1));
        issue(1, 0, 1, 1, 1, 8'h00, 1'b1, 4, {8'h96, 1'b1}, 1'b0);
        wait_done(400);

        // START only, then repeated START + WRITE 55, then STOP only
        sb.push_back(mk("start_only", 17, 8'h96, 1'b1, 1'b1, 1'b1, 0, 32'b0, 1, 0));
        issue(1, 0, 0, 0, 0, 8'h00, 1'b0, 0, 9'h1FF, 1'b0);
        wait_done(400);
        sb.push_back(mk("rstart_wr_55", 161, 8'h96, 1'b0, 1'b1, 1'b1, 10, 32'b1010101010, 1, 0));
        issue(1, 1, 0, 0, 0, 8'h55, 1'b1, 4, 9'h1FE, 1'b0);
        wait_done(400);
        chk("owned.scl_held_low", int'(scl_oe), 1);
        sb.push_back(mk("stop_only", 17, 8'h96, 1'b0, 1'b0, 1'b1, 1, 32'b0, 0, 1));
        issue(0, 0, 0, 1, 0, 8'h00, 1'b0, 0, 9'h1FF, 1'b0);
        wait_done(400);

        // WRITE 3C with SCL stretched for 20 cycles in Q1 of the first bit
        repeat (30) @(posedge clk);
        sb.push_back(mk("wr_3c_stretch", 165, 8'h96, 1'b1, 1'b0, 1'b0, 9, 32'b001111001, 0, 0));
        issue(0, 1, 0, 0, 0, 8'h3C, 1'b0, 0, 9'h1FF, 1'b1);
        wait_done(400);

        // empty command
        sb.push_back(mk("empty", 1, 8'h96, 1'b1, 1'b0, 1'b0, 0, 32'b0, 0, 0));
        issue(0, 0, 0, 0, 0, 8'h00, 1'b0, 0, 9'h1FF, 1'b0);
        wait_done(50);
        chk("empty.scl_unchanged", int'(scl_oe), 1);
        chk("empty.sda_unchanged", int'(sda_oe), 0);

        // reset in the middle of a write byte
        issue(1, 1, 0, 1, 0, 8'h81, 1'b0, 0, 9'h1FF, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.scl_oe", int'(scl_oe), 0);
        chk("midrst.sda_oe", int'(sda_oe), 0);
        chk("midrst.cmd_ready", int'(cmd_ready), 1);
        chk("midrst.bus_owned", int'(bus_owned), 0);
        chk("midrst.done", int'(done), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
